// File: rtl/onehot_pkg.sv
// -----------------------------------------------------------------------------
// onehot_pkg
// Shared definitions for the parametrised one-hot counter:
//   - mode and direction encodings
//   - MAX_W : widest vector accepted by the helper functions
//   - is_onehot() : exactly-one-bit-set test, used both for load validation
//                   and for detecting corrupted counter state
// -----------------------------------------------------------------------------
package onehot_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Helper functions take a fixed-width argument; callers zero-extend into it,
  // which leaves the one-hot property unchanged. Counters wider than this are
  // not supported.
  localparam int MAX_W = 256;

  localparam logic [MAX_W-1:0] ONE_W = {{(MAX_W-1){1'b0}}, 1'b1};

  // Non-zero and clearing the lowest set bit leaves nothing behind.
  function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
    return (vec != {MAX_W{1'b0}}) && ((vec & (vec - ONE_W)) == {MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/onehot_counter_gen_encoder.sv
// -----------------------------------------------------------------------------
// onehot_encoder
// One-hot to binary index converter. Reports the position of the lowest set
// bit, or 0 when no bit is set. Only meaningful for legal (one-hot) input.
// Ports:
//   onehot  in  WIDTH  : vector to encode
//   idx     out IDX_W  : binary position of the lowest set bit
// -----------------------------------------------------------------------------
module onehot_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  // Priority scan from the top down so the lowest set bit is written last.
  always_comb begin
    idx = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/onehot_counter_gen.sv
// -----------------------------------------------------------------------------
// onehot_counter_gen
// Parametrised one-hot counter with up/down direction, rotate or bounce
// (ping-pong) stepping, validated parallel load and self-correction of
// corrupted state. Priority each cycle: load, correction, step, hold.
// Ports:
//   clk       in  1      : clock, rising edge
//   rst_n     in  1      : asynchronous active-low reset
//   en        in  1      : advance one position
//   dir       in  1      : 1 = up (toward MSB), 0 = down
//   mode      in  1      : 0 = rotate, 1 = bounce
//   load      in  1      : parallel load request
//   load_val  in  WIDTH  : value to load (must be one-hot)
//   out       out WIDTH  : registered one-hot state
//   idx       out IDX_W  : binary position of the set bit in out
//   cur_dir   out 1      : registered direction in effect
//   wrap      out 1      : one-cycle pulse on end-of-range wrap or reversal
//   err       out 1      : one-cycle pulse after an illegal state was corrected
//   load_err  out 1      : one-cycle pulse after a load was rejected
// -----------------------------------------------------------------------------
module onehot_counter_gen
  import onehot_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             cur_dir,
  output logic             wrap,
  output logic             err,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] RESET_STATE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             dir_q;
  logic             dir_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             err_q;
  logic             err_d;
  logic             load_err_q;
  logic             load_err_d;

  logic             state_legal;
  logic             load_legal;
  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_down;
  logic             at_msb;
  logic             at_lsb;
  logic             hold_dir;

  assign state_legal = is_onehot(MAX_W'(state_q));
  assign load_legal  = is_onehot(MAX_W'(load_val));

  // Circular shifts; the rotate and bounce paths both build on these.
  assign step_up   = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
  assign step_down = {state_q[0], state_q[WIDTH-1:1]};
  assign at_msb    = state_q[WIDTH-1];
  assign at_lsb    = state_q[0];

  // Direction kept on cycles that do not step: rotate mode follows the dir
  // input every cycle, bounce mode only changes direction on accepted loads
  // and end-of-range reversals.
  assign hold_dir = (mode == MODE_ROTATE) ? dir : dir_q;

  // Next-state selection: load, then correction, then step, then hold.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_legal) begin
        state_d = load_val;
        dir_d   = dir;
      end else begin
        load_err_d = 1'b1;
        dir_d      = hold_dir;
      end
    end else if (!state_legal) begin
      state_d = RESET_STATE;
      err_d   = 1'b1;
      dir_d   = hold_dir;
    end else begin
      case (mode)
        MODE_ROTATE: begin
          dir_d = dir;
          if (en) begin
            if (dir == DIR_UP) begin
              state_d = step_up;
              wrap_d  = at_msb;
            end else begin
              state_d = step_down;
              wrap_d  = at_lsb;
            end
          end else begin
            state_d = state_q;
          end
        end
        MODE_BOUNCE: begin
          if (en) begin
            // At the end of the range, reverse and take the step the other way.
            if (dir_q == DIR_UP) begin
              if (at_msb) begin
                dir_d   = DIR_DOWN;
                state_d = step_down;
                wrap_d  = 1'b1;
              end else begin
                state_d = step_up;
              end
            end else begin
              if (at_lsb) begin
                dir_d   = DIR_UP;
                state_d = step_up;
                wrap_d  = 1'b1;
              end else begin
                state_d = step_down;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, direction and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      dir_q      <= DIR_UP;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      load_err_q <= load_err_d;
    end
  end

  onehot_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .onehot (state_q),
    .idx    (idx)
  );

  assign out      = state_q;
  assign cur_dir  = dir_q;
  assign wrap     = wrap_q;
  assign err      = err_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_onehot_counter_gen.sv
// -----------------------------------------------------------------------------
// tb_onehot_counter_gen
// Self-checking bench for onehot_counter_gen at WIDTH = 8. A position-based
// behavioural model is advanced on every rising edge and all outputs are
// compared against it on every falling edge; directed scenarios add literal
// expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_onehot_counter_gen;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  out;
  logic [IW-1:0] idx;
  logic          cur_dir;
  logic          wrap;
  logic          err;
  logic          load_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [W-1:0] m_out;
  logic         m_dir;
  logic         m_wrap;
  logic         m_err;
  logic         m_lerr;

  localparam logic [7:0] UP_SEQ [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                        8'h40, 8'h80, 8'h01, 8'h02};
  localparam int         UP_IDX [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  onehot_counter_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .idx      (idx),
    .cur_dir  (cur_dir),
    .wrap     (wrap),
    .err      (err),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic int popcount(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out  = 8'h01;
    m_dir  = 1'b1;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    m_lerr = 1'b0;
  endtask

  // Advance the model by one clock using the position of the set bit.
  task automatic model_step();
    int p;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    m_lerr = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      if (popcount(load_val) == 1) begin
        m_out = load_val;
        m_dir = dir;
      end else begin
        m_lerr = 1'b1;
        if (!mode) m_dir = dir;
      end
    end else if (popcount(m_out) != 1) begin
      m_out = 8'h01;
      m_err = 1'b1;
      if (!mode) m_dir = dir;
    end else begin
      p = lowest(m_out);
      if (!mode) begin
        m_dir = dir;
        if (en) begin
          if (dir) begin
            m_wrap = (p == W - 1);
            p = (p + 1) % W;
          end else begin
            m_wrap = (p == 0);
            p = (p + W - 1) % W;
          end
        end
      end else if (en) begin
        if (m_dir) begin
          if (p == W - 1) begin m_dir = 1'b0; p = p - 1; m_wrap = 1'b1; end
          else p = p + 1;
        end else begin
          if (p == 0) begin m_dir = 1'b1; p = 1; m_wrap = 1'b1; end
          else p = p - 1;
        end
      end
      m_out = '0;
      m_out[p] = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("out", 32'(out), 32'(m_out));
    chk("idx", 32'(idx), 32'(lowest(m_out)));
    chk("cur_dir", 32'(cur_dir), 32'(m_dir));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("err", 32'(err), 32'(m_err));
    chk("load_err", 32'(load_err), 32'(m_lerr));
  endtask

  // One clock: model follows the rising edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) tick();
    chk("reset_out", 32'(out), 32'h01);
    chk("reset_idx", 32'(idx), 32'h0);
    chk("reset_dir", 32'(cur_dir), 32'h1);
    chk("reset_pulses", 32'({wrap, err, load_err}), 32'h0);

    // Rotate up from reset, nine steps.
    rst_n = 1'b1; en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rot_up_out", 32'(out), 32'(UP_SEQ[k]));
      chk("rot_up_idx", 32'(idx), 32'(UP_IDX[k]));
      chk("rot_up_wrap", 32'(wrap), 32'(k == 7));
    end

    // Rotate down from reset.
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1; dir = 1'b0; en = 1'b1;
    tick();
    chk("rot_dn_out0", 32'(out), 32'h80);
    chk("rot_dn_wrap0", 32'(wrap), 32'h1);
    tick();
    chk("rot_dn_out1", 32'(out), 32'h40);
    chk("rot_dn_idx1", 32'(idx), 32'h6);
    chk("rot_dn_wrap1", 32'(wrap), 32'h0);

    // Bounce off the MSB; dir input held at 1 must be ignored.
    load = 1'b1; load_val = 8'h40; dir = 1'b1; en = 1'b1;
    tick();
    chk("bnc_load_out", 32'(out), 32'h40);
    load = 1'b0; mode = 1'b1;
    tick();
    chk("bnc_out0", 32'(out), 32'h80);
    tick();
    chk("bnc_out1", 32'(out), 32'h40);
    chk("bnc_wrap1", 32'(wrap), 32'h1);
    chk("bnc_dir1", 32'(cur_dir), 32'h0);
    tick();
    chk("bnc_out2", 32'(out), 32'h20);
    tick();
    chk("bnc_out3", 32'(out), 32'h10);
    chk("bnc_dir3", 32'(cur_dir), 32'h0);

    // Asynchronous reset between edges.
    en = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_out", 32'(out), 32'h01);
    chk("async_dir", 32'(cur_dir), 32'h1);
    chk("async_idx", 32'(idx), 32'h0);
    chk("async_pulses", 32'({wrap, err, load_err}), 32'h0);
    tick();
    rst_n = 1'b1;

    // Load validation.
    mode = 1'b0; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h20;
    tick();
    chk("ld_ok_out", 32'(out), 32'h20);
    chk("ld_ok_idx", 32'(idx), 32'h5);
    load_val = 8'h30;
    tick();
    chk("ld_bad2_out", 32'(out), 32'h20);
    chk("ld_bad2_err", 32'(load_err), 32'h1);
    load_val = 8'h00;
    tick();
    chk("ld_bad0_out", 32'(out), 32'h20);
    chk("ld_bad0_err", 32'(load_err), 32'h1);
    load = 1'b0; en = 1'b0;
    tick();
    chk("ld_err_clr", 32'(load_err), 32'h0);

    // Illegal-state recovery: all-zero, then two bits set.
    en = 1'b1;
    force dut.state_q = 8'h00;
    m_out = 8'h00;
    #1 release dut.state_q;
    chk("inj_zero", 32'(out), 32'h00);
    tick();
    chk("fix0_out", 32'(out), 32'h01);
    chk("fix0_err", 32'(err), 32'h1);
    tick();
    chk("fix0_err_clr", 32'(err), 32'h0);
    force dut.state_q = 8'h81;
    m_out = 8'h81;
    #1 release dut.state_q;
    chk("inj_two", 32'(out), 32'h81);
    tick();
    chk("fix2_out", 32'(out), 32'h01);
    chk("fix2_err", 32'(err), 32'h1);
    tick();
    chk("fix2_err_clr", 32'(err), 32'h0);

    // Mixed sweep: mode and direction changes mid-count, bounce off bit 0.
    for (int k = 0; k < 60; k++) begin
      dir  = k[1];
      mode = ((k / 9) % 2) == 1;
      en   = (k % 7) != 3;
      load = (k == 40);
      load_val = 8'h04;
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
